// File: rtl/rv_iopmp_entry_port_arbiter.sv
// Single-port IOPMP entry SRAM arbiter: config port vs. N round-robin checkers,
// with starvation override, read-return routing, stall broadcast and write generation.
module rv_iopmp_entry_port_arbiter #(
  parameter int NUM_CHECKERS   = 2,
  parameter int NUMBER_ENTRIES = 8,
  parameter int ENTRY_WIDTH    = 128,
  parameter int READ_LATENCY   = 1,
  parameter int STARVE_LIMIT   = 4,
  parameter int GEN_WIDTH      = 8,
  localparam int AW = (NUMBER_ENTRIES > 1) ? $clog2(NUMBER_ENTRIES) : 1,
  localparam int BW = ENTRY_WIDTH / 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cfg_req_i,
  input  logic                       cfg_we_i,
  input  logic [AW-1:0]              cfg_addr_i,
  input  logic [ENTRY_WIDTH-1:0]     cfg_wdata_i,
  input  logic [BW-1:0]              cfg_be_i,
  output logic                       cfg_gnt_o,
  output logic                       cfg_rvalid_o,
  output logic [ENTRY_WIDTH-1:0]     cfg_rdata_o,
  input  logic [NUM_CHECKERS-1:0]    chk_req_i,
  input  logic [NUM_CHECKERS*AW-1:0] chk_addr_i,
  output logic [NUM_CHECKERS-1:0]    chk_gnt_o,
  output logic [NUM_CHECKERS-1:0]    chk_rvalid_o,
  output logic [ENTRY_WIDTH-1:0]     chk_rdata_o,
  output logic                       chk_stall_o,
  output logic [GEN_WIDTH-1:0]       entry_gen_o,
  output logic                       mem_req_o,
  output logic                       mem_we_o,
  output logic [AW-1:0]              mem_addr_o,
  output logic [ENTRY_WIDTH-1:0]     mem_wdata_o,
  output logic [BW-1:0]              mem_be_o,
  input  logic [ENTRY_WIDTH-1:0]     mem_rdata_i
);

  localparam int IW = (NUM_CHECKERS > 1) ? $clog2(NUM_CHECKERS) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = $clog2(READ_LATENCY + 2);

  logic [IW-1:0] rr_ptr;
  logic [SW-1:0] starve_cnt;
  logic [LW-1:0] stall_cnt;
  logic [IW-1:0] win_idx;
  logic          any_chk;
  logic          starve_override;
  logic          cfg_win;
  logic          chk_win;
  logic          rd_acc;
  logic          wr_acc;
  logic          out_vld;

  logic          pipe_vld [READ_LATENCY];
  logic          pipe_cfg [READ_LATENCY];
  logic [IW-1:0] pipe_idx [READ_LATENCY];

  // First requesting checker at or after rr_ptr, wrapping.
  always_comb begin
    logic found;
    int   idx;
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_CHECKERS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_CHECKERS;
      if (!found && chk_req_i[IW'(idx)]) begin
        found   = 1'b1;
        win_idx = IW'(idx);
      end
    end
  end

  assign any_chk         = |chk_req_i;
  assign starve_override = (starve_cnt >= SW'(STARVE_LIMIT));
  assign cfg_win         = cfg_req_i && !(starve_override && any_chk);
  assign cfg_gnt_o       = !rst_i && cfg_win;
  assign chk_win         = !rst_i && any_chk && !cfg_win;
  assign chk_gnt_o       = chk_win ? (NUM_CHECKERS'(1) << win_idx) : '0;
  assign rd_acc          = (cfg_gnt_o && !cfg_we_i) || chk_win;
  assign wr_acc          = cfg_gnt_o && cfg_we_i;

  always_comb begin
    mem_req_o   = cfg_gnt_o || chk_win;
    mem_we_o    = 1'b0;
    mem_addr_o  = chk_addr_i[win_idx*AW +: AW];
    mem_wdata_o = '0;
    mem_be_o    = '1;
    if (cfg_gnt_o) begin
      mem_we_o    = cfg_we_i;
      mem_addr_o  = cfg_addr_i;
      mem_wdata_o = cfg_wdata_i;
      mem_be_o    = cfg_we_i ? cfg_be_i : '1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr      <= '0;
      starve_cnt  <= '0;
      entry_gen_o <= '0;
      stall_cnt   <= '0;
    end else begin
      if (chk_win) begin
        rr_ptr <= (win_idx == IW'(NUM_CHECKERS - 1)) ? '0 : win_idx + IW'(1);
      end
      if (chk_win || !any_chk) begin
        starve_cnt <= '0;
      end else if (cfg_gnt_o && !starve_override) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
      if (wr_acc) begin
        entry_gen_o <= entry_gen_o + GEN_WIDTH'(1);
        stall_cnt   <= LW'(READ_LATENCY + 1);
      end else if (stall_cnt != '0) begin
        stall_cnt <= stall_cnt - LW'(1);
      end
    end
  end

  assign chk_stall_o = (stall_cnt != '0);

  // Return pipeline: tags each accepted read with its owner until the SRAM answers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_cfg[i] <= 1'b0;
        pipe_idx[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_acc;
      pipe_cfg[0] <= cfg_gnt_o;
      pipe_idx[0] <= win_idx;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_cfg[i] <= pipe_cfg[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  assign out_vld      = pipe_vld[READ_LATENCY-1] && !rst_i;
  assign cfg_rvalid_o = out_vld && pipe_cfg[READ_LATENCY-1];
  assign chk_rvalid_o = (out_vld && !pipe_cfg[READ_LATENCY-1]) ?
                        (NUM_CHECKERS'(1) << pipe_idx[READ_LATENCY-1]) : '0;
  assign cfg_rdata_o  = mem_rdata_i;
  assign chk_rdata_o  = mem_rdata_i;

endmodule
